// File: rtl/mlp_tmux_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : mlp_tmux_engine_if
//  Purpose  : Input/output handshake and coefficient bus of mlp_tmux_engine.
//  Revision : 1.0 - initial release
// ============================================================================
interface mlp_tmux_engine_if #(
    parameter int L  = 1,
    parameter int N  = 4,
    parameter int QM = 3,
    parameter int QN = 5,
    parameter int WM = 3,
    parameter int WN = 5
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [QM+QN-1:0]  x [N];
    logic signed [WM+WN-1:0]  w [L][N][N];
    logic signed [QM+QN-1:0]  b [L][N];
    logic                     out_valid;
    logic                     out_ready;
    logic signed [QM+QN-1:0]  y [N];
    logic                     busy;

    modport master (
        output in_valid, x, w, b, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  in_valid, x, w, b, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface
`default_nettype wire

// File: rtl/mlp_tmux_engine.sv
`default_nettype none
// ============================================================================
//  Module   : mlp_tmux_engine
//  Purpose  : L-layer, N-neuron MLP evaluated through P shared MAC lanes with
//             ping-pong activation buffers. Macro MLP_ROUND_EN selects
//             round-half-up instead of truncation on the write-back shift.
//  Revision : 1.0 - initial release
// ============================================================================
module mlp_tmux_engine #(
    parameter int L  = 1,
    parameter int N  = 4,
    parameter int P  = 2,
    parameter int QM = 3,
    parameter int QN = 5,
    parameter int WM = 3,
    parameter int WN = 5
) (
    input  logic             clk,
    input  logic             nrst,
    mlp_tmux_engine_if.slave bus
);
    localparam int DW = QM + QN;
    localparam int WW = WM + WN;
    localparam int PW = DW + WW;
    localparam int AW = PW + $clog2(N) + 1;
    localparam int SW = AW + 1;
    localparam int G  = N / P;
    localparam int JW = (N > 1) ? $clog2(N) : 1;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int LW = (L > 1) ? $clog2(L) : 1;

    localparam logic signed [SW-1:0] MAXV = SW'((longint'(1) <<< (DW - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = SW'(-(longint'(1) <<< (DW - 1)));
`ifdef MLP_ROUND_EN
    localparam logic signed [SW-1:0] RND  = SW'(longint'(1) <<< (WN - 1));
`else
    localparam logic signed [SW-1:0] RND  = '0;
`endif

    if (N % P != 0) begin : g_bad_lanes
        $error("mlp_tmux_engine: N must be a multiple of P");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   sel_q;
    logic [LW-1:0]          l_q;
    logic [GW-1:0]          g_q;
    logic [JW-1:0]          j_q;
    logic signed [AW-1:0]   acc_q [P];
    logic signed [DW-1:0]   act_q [2][N];
    logic signed [DW-1:0]   y_q   [N];

    logic                   in_ready_c, out_valid_c, busy_c;
    logic                   last_j, last_g, last_l;
    logic signed [DW-1:0]   act_j;
    logic [JW-1:0]          nidx [P];
    logic signed [PW-1:0]   prod [P];
    logic signed [SW-1:0]   sum  [P];
    logic signed [SW-1:0]   shr  [P];
    logic signed [DW-1:0]   res  [P];

    assign last_j = (j_q == JW'(N - 1));
    assign last_g = (g_q == GW'(G - 1));
    assign last_l = (l_q == LW'(L - 1));

    // Per-lane MAC product and write-back value; w and b are read live.
    always_comb begin
        act_j = act_q[sel_q][j_q];
        for (int k = 0; k < P; k++) begin
            nidx[k] = JW'(int'(g_q) * P + k);
            prod[k] = PW'(act_j) * PW'(bus.w[l_q][nidx[k]][j_q]);
            sum[k]  = SW'(acc_q[k]) + (SW'(bus.b[l_q][nidx[k]]) <<< WN) + RND;
            shr[k]  = sum[k] >>> WN;
            if (shr[k] > MAXV)
                res[k] = DW'(MAXV);
            else if (shr[k] < MINV)
                res[k] = DW'(MINV);
            else
                res[k] = shr[k][DW-1:0];
            if (!last_l && res[k][DW-1])
                res[k] = '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid)
                    state_d = S_MAC;
            end
            S_MAC: begin
                busy_c = 1'b1;
                if (last_j)
                    state_d = S_WB;
            end
            S_WB: begin
                busy_c  = 1'b1;
                state_d = (last_g && last_l) ? S_DONE : S_MAC;
            end
            S_DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sel_q <= 1'b0;
            l_q   <= '0;
            g_q   <= '0;
            j_q   <= '0;
            for (int k = 0; k < P; k++)
                acc_q[k] <= '0;
            for (int i = 0; i < N; i++) begin
                act_q[0][i] <= '0;
                act_q[1][i] <= '0;
                y_q[i]      <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < N; i++)
                            act_q[0][i] <= bus.x[i];
                        sel_q <= 1'b0;
                        l_q   <= '0;
                        g_q   <= '0;
                        j_q   <= '0;
                        for (int k = 0; k < P; k++)
                            acc_q[k] <= '0;
                    end
                end
                S_MAC: begin
                    for (int k = 0; k < P; k++)
                        acc_q[k] <= acc_q[k] + AW'(prod[k]);
                    j_q <= last_j ? '0 : j_q + 1'b1;
                end
                S_WB: begin
                    // y is a dedicated register so a new accept cannot disturb it.
                    for (int k = 0; k < P; k++) begin
                        act_q[~sel_q][nidx[k]] <= res[k];
                        if (last_l)
                            y_q[nidx[k]] <= res[k];
                        acc_q[k] <= '0;
                    end
                    if (!last_g) begin
                        g_q <= g_q + 1'b1;
                    end else if (!last_l) begin
                        l_q   <= l_q + 1'b1;
                        g_q   <= '0;
                        sel_q <= ~sel_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c & nrst;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.y         = y_q;

endmodule
`default_nettype wire

// File: tb/tb_mlp_tmux_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mlp_tmux_engine
//  Purpose  : Directed self-checking bench for mlp_tmux_engine (three configs).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mlp_tmux_engine;
    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mlp_tmux_engine_if #(.L(1), .N(2)) ifa ();
    mlp_tmux_engine_if #(.L(1), .N(2)) ifb ();
    mlp_tmux_engine_if #(.L(2), .N(2)) ifc ();

    mlp_tmux_engine #(.L(1), .N(2), .P(1)) dut_a (.clk(clk), .nrst(nrst), .bus(ifa));
    mlp_tmux_engine #(.L(1), .N(2), .P(2)) dut_b (.clk(clk), .nrst(nrst), .bus(ifb));
    mlp_tmux_engine #(.L(2), .N(2), .P(1)) dut_c (.clk(clk), .nrst(nrst), .bus(ifc));

    logic              ov  [3];
    logic              bsy [3];
    logic signed [7:0] y0s [3];
    assign ov[0]  = ifa.out_valid;  assign ov[1]  = ifb.out_valid;  assign ov[2]  = ifc.out_valid;
    assign bsy[0] = ifa.busy;       assign bsy[1] = ifb.busy;       assign bsy[2] = ifc.busy;
    assign y0s[0] = ifa.y[0];       assign y0s[1] = ifb.y[0];       assign y0s[2] = ifc.y[0];

`ifdef MLP_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Caller has raised in_valid; completes the accept edge and times out_valid.
    task automatic run(input int d, input int exp_lat, input logic signed [63:0] y0_prev, input string tag);
        int lat;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0; ifb.in_valid = 1'b0; ifc.in_valid = 1'b0;
        chk({tag, "_busy"}, bsy[d], 1);
        chk({tag, "_y_held"}, y0s[d], y0_prev);
        lat = 0;
        while (!ov[d] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic drain();
        ifa.out_ready = 1'b1; ifb.out_ready = 1'b1; ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifa.out_ready = 1'b0; ifb.out_ready = 1'b0; ifc.out_ready = 1'b0;
    endtask

    initial begin
        ifa.in_valid = 0; ifa.out_ready = 0; ifa.x = '{default:'0}; ifa.w = '{default:'0}; ifa.b = '{default:'0};
        ifb.in_valid = 0; ifb.out_ready = 0; ifb.x = '{default:'0}; ifb.w = '{default:'0}; ifb.b = '{default:'0};
        ifc.in_valid = 0; ifc.out_ready = 0; ifc.x = '{default:'0}; ifc.w = '{default:'0}; ifc.b = '{default:'0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", ifa.in_ready, 0);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_y0", ifa.y[0], 0);
        nrst = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", ifa.in_ready, 1);
        chk("rel_c_in_ready", ifc.in_ready, 1);

        // Identity, then backpressure in DONE
        ifa.x[0] = 32; ifa.x[1] = 64;
        ifa.w[0][0][0] = 32; ifa.w[0][1][1] = 32;
        ifa.in_valid = 1'b1;
        run(0, 6, 0, "ident");
        chk("ident_y0", ifa.y[0], 32);
        chk("ident_y1", ifa.y[1], 64);
        repeat (5) begin @(posedge clk); #1; end
        chk("bp_out_valid", ifa.out_valid, 1);
        chk("bp_in_ready", ifa.in_ready, 0);
        chk("bp_busy", ifa.busy, 0);
        chk("bp_y0", ifa.y[0], 32);
        chk("bp_y1", ifa.y[1], 64);
        drain();
        chk("hs_out_valid", ifa.out_valid, 0);
        chk("hs_in_ready", ifa.in_ready, 1);
        chk("hs_y1", ifa.y[1], 64);

        // Rounding: +16/32 and -16/32 of an LSB
        ifa.x[0] = 1; ifa.x[1] = 0;
        ifa.w[0][0][0] = 16; ifa.w[0][1][1] = 0;
        ifa.in_valid = 1'b1;
        run(0, 6, 32, "rndp");
        chk("rndp_y0", ifa.y[0], ROUND ? 1 : 0);
        chk("rndp_y1", ifa.y[1], 0);
        drain();
        ifa.x[0] = -1;
        ifa.in_valid = 1'b1;
        run(0, 6, ROUND ? 1 : 0, "rndn");
        chk("rndn_y0", ifa.y[0], ROUND ? 0 : -1);
        drain();

        // Saturation, P = N
        ifb.x[0] = 127; ifb.x[1] = 127;
        ifb.w[0][0][0] = 127; ifb.w[0][0][1] = 127; ifb.w[0][1][0] = 127; ifb.w[0][1][1] = 127;
        ifb.in_valid = 1'b1;
        run(1, 3, 0, "satp");
        chk("satp_y0", ifb.y[0], 127);
        chk("satp_y1", ifb.y[1], 127);
        drain();
        ifb.w[0][0][0] = -128; ifb.w[0][0][1] = -128; ifb.w[0][1][0] = -128; ifb.w[0][1][1] = -128;
        ifb.in_valid = 1'b1;
        run(1, 3, 127, "satn");
        chk("satn_y0", ifb.y[0], -128);
        chk("satn_y1", ifb.y[1], -128);
        drain();

        // Hidden-layer ReLU
        ifc.x[0] = 32; ifc.x[1] = 32;
        ifc.w[0][0][0] = -32; ifc.w[0][1][1] = -32;
        ifc.w[1][0][0] = 32;  ifc.w[1][1][1] = 32;
        ifc.b[1][0] = 16;
        ifc.in_valid = 1'b1;
        run(2, 12, 0, "relu");
        chk("relu_y0", ifc.y[0], 16);
        chk("relu_y1", ifc.y[1], 0);
        drain();

        // Reset during group 0 MAC
        ifa.x[0] = 32; ifa.x[1] = 64;
        ifa.w[0][0][0] = 32; ifa.w[0][1][1] = 32;
        ifa.in_valid = 1'b1;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b0;
        #1;
        chk("mrst_in_ready", ifa.in_ready, 0);
        chk("mrst_busy", ifa.busy, 0);
        chk("mrst_out_valid", ifa.out_valid, 0);
        chk("mrst_b_y0", ifb.y[0], 0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        ifa.x[0] = -32; ifa.x[1] = 96;
        ifa.in_valid = 1'b1;
        run(0, 6, 0, "fresh");
        chk("fresh_y0", ifa.y[0], -32);
        chk("fresh_y1", ifa.y[1], 96);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
